// File: rtl/zynq_drain_pkg.sv
// Shared definitions for the Zynq-side readout FIFO drain.
//   - FSM state encoding (IDLE, REQ, HDR, DATA, DONE)
//   - default header tag, abort word and sample-count width
package zynq_drain_pkg;

    localparam int          CNT_W_DEF   = 12;
    localparam logic [15:0] HDR_TAG_DEF = 16'hA5C3;
    localparam logic [15:0] ABORT_WORD  = 16'hDEAD;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_HDR  = 3'd2,
        ST_DATA = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/drain_pack16to32.sv
// Half-beat packer with a one-entry registered stream output.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   load_hdr, hdr_word   place a header beat in the output register
//   push, push_data      one 16-bit sample popped from the FIFO this cycle
//   push_last            the pushed sample is the final sample of the frame
//   abort                flush a held half (or the abort word) as the last beat
//   m_tready             downstream ready
//   m_tdata/m_tvalid/m_tlast  registered stream outputs
//   slot_free            output register is empty or is being accepted now
// Callers only assert load_hdr / push / abort while slot_free is high.
module drain_pack16to32
    import zynq_drain_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_hdr,
    input  logic [31:0]       hdr_word,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              push_last,
    input  logic              abort,
    input  logic              m_tready,
    output logic [31:0]       m_tdata,
    output logic              m_tvalid,
    output logic              m_tlast,
    output logic              slot_free
);

    logic [31:0]       tdata_r;
    logic              tvalid_r;
    logic              tlast_r;
    logic [DATA_W-1:0] half_r;
    logic              half_valid_r;
    logic              fire_s;

    assign fire_s    = tvalid_r & m_tready;
    assign slot_free = ~tvalid_r | m_tready;
    assign m_tdata   = tdata_r;
    assign m_tvalid  = tvalid_r;
    assign m_tlast   = tlast_r;

    // Output register and half-beat holding register; a new beat may replace
    // one that is being accepted in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tdata_r      <= 32'h0000_0000;
            tvalid_r     <= 1'b0;
            tlast_r      <= 1'b0;
            half_r       <= '0;
            half_valid_r <= 1'b0;
        end else if (load_hdr) begin
            tdata_r      <= hdr_word;
            tvalid_r     <= 1'b1;
            tlast_r      <= 1'b0;
            half_valid_r <= 1'b0;
        end else if (abort) begin
            // A held lower half goes out alone; otherwise mark the frame as aborted.
            tdata_r      <= half_valid_r ? {16'h0000, half_r} : {ABORT_WORD, 16'h0000};
            tvalid_r     <= 1'b1;
            tlast_r      <= 1'b1;
            half_valid_r <= 1'b0;
        end else if (push && half_valid_r) begin
            tdata_r      <= {push_data, half_r};
            tvalid_r     <= 1'b1;
            tlast_r      <= push_last;
            half_valid_r <= 1'b0;
        end else if (push && push_last) begin
            // Odd-length frame: final sample rides alone in the lower half.
            tdata_r      <= {16'h0000, push_data};
            tvalid_r     <= 1'b1;
            tlast_r      <= 1'b1;
        end else if (push) begin
            half_r       <= push_data;
            half_valid_r <= 1'b1;
            if (fire_s) begin
                tvalid_r <= 1'b0;
            end else begin
                tvalid_r <= tvalid_r;
            end
        end else if (fire_s) begin
            tvalid_r <= 1'b0;
        end else begin
            tvalid_r <= tvalid_r;
        end
    end

endmodule

// File: rtl/zynq_fifo_drain.sv
// Zynq-side consumer of the multi-channel readout FIFO.
// Requests a read window from the readout controller, pops exactly the
// latched number of samples and streams them as a header beat followed by
// 32-bit beats of two packed samples.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start             software read request (pulse)
//   fifo_count/fifo_empty/fifo_dout/fifo_rd   FWFT readout FIFO
//   fifo_rd_en        controller read-window grant
//   zynq_rd_rq        read request to controller
//   howmany_left      samples still to pop
//   m_tdata/m_tvalid/m_tready/m_tlast         stream to the DMA
//   busy, err, frame_cnt                      status
module zynq_fifo_drain
    import zynq_drain_pkg::*;
#(
    parameter int               DATA_W    = 16,
    parameter int               CNT_W     = CNT_W_DEF,
    parameter logic [CNT_W-1:0] MAX_WORDS = 12'd2048,
    parameter int               TIMEOUT   = 256,
    parameter logic [15:0]      HDR_TAG   = HDR_TAG_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  fifo_count,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              fifo_rd,
    input  logic              fifo_rd_en,
    output logic              zynq_rd_rq,
    output logic [CNT_W-1:0]  howmany_left,
    output logic [31:0]       m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast,
    output logic              busy,
    output logic              err,
    output logic [15:0]       frame_cnt
);

    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] n_r;
    logic [CNT_W-1:0] left_r;
    logic [CNT_W-1:0] n_clamp_s;
    logic [TO_W-1:0]  to_cnt_r;
    logic [15:0]      frame_cnt_r;
    logic             rq_r;
    logic             busy_r;
    logic             err_r;
    logic             accept_s;
    logic             load_hdr_s;
    logic             pop_s;
    logic             abort_s;
    logic             starve_s;
    logic             slot_free_s;
    logic             fire_s;

    assign fire_s       = m_tvalid & m_tready;
    assign fifo_rd      = pop_s;
    assign zynq_rd_rq   = rq_r;
    assign busy         = busy_r;
    assign err          = err_r;
    assign howmany_left = left_r;
    assign frame_cnt    = frame_cnt_r;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic and per-cycle strobes.
    always_comb begin
        state_s    = state_r;
        accept_s   = 1'b0;
        load_hdr_s = 1'b0;
        pop_s      = 1'b0;
        abort_s    = 1'b0;
        n_clamp_s  = (fifo_count > MAX_WORDS) ? MAX_WORDS : fifo_count;
        // Starved cycle: data still owed, FIFO empty, and not held off by the stream.
        starve_s   = (state_r == ST_DATA) & fifo_empty & (left_r != '0) & slot_free_s;
        case (state_r)
            ST_IDLE: begin
                if (start && (fifo_count != '0)) begin
                    accept_s = 1'b1;
                    state_s  = ST_REQ;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (fifo_rd_en) begin
                    load_hdr_s = 1'b1;
                    state_s    = ST_HDR;
                end else begin
                    state_s    = ST_REQ;
                end
            end
            ST_HDR: begin
                if (fire_s) begin
                    state_s = ST_DATA;
                end else begin
                    state_s = ST_HDR;
                end
            end
            ST_DATA: begin
                pop_s = ~fifo_empty & (left_r != '0) & slot_free_s;
                if (starve_s && (to_cnt_r == TO_W'(TIMEOUT - 1))) begin
                    abort_s = 1'b1;
                end else begin
                    abort_s = 1'b0;
                end
                // The frame ends when its tlast beat (normal or abort) is taken.
                if (fire_s && m_tlast) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Frame length, remaining count, error flag and frame counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_r         <= '0;
            left_r      <= '0;
            err_r       <= 1'b0;
            frame_cnt_r <= 16'h0000;
        end else begin
            if (accept_s) begin
                n_r    <= n_clamp_s;
                left_r <= n_clamp_s;
                err_r  <= 1'b0;
            end else if (abort_s) begin
                left_r <= '0;
                err_r  <= 1'b1;
            end else if (pop_s) begin
                left_r <= left_r - {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                left_r <= left_r;
            end
            if (state_r == ST_DONE) begin
                frame_cnt_r <= frame_cnt_r + 16'd1;
            end else begin
                frame_cnt_r <= frame_cnt_r;
            end
        end
    end

    // Starvation timer: counts consecutive starved cycles, frozen while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_r <= '0;
        end else if ((state_r != ST_DATA) || !fifo_empty || pop_s || abort_s || (left_r == '0)) begin
            to_cnt_r <= '0;
        end else if (starve_s) begin
            to_cnt_r <= to_cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
        end else begin
            to_cnt_r <= to_cnt_r;
        end
    end

    // Registered handshake and status outputs, aligned with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rq_r   <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            rq_r   <= (state_s == ST_REQ);
            busy_r <= (state_s != ST_IDLE);
        end
    end

    drain_pack16to32 #(
        .DATA_W (DATA_W)
    ) u_pack (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_hdr  (load_hdr_s),
        .hdr_word  ({HDR_TAG, 16'(n_r)}),
        .push      (pop_s),
        .push_data (fifo_dout),
        .push_last (left_r == {{(CNT_W-1){1'b0}}, 1'b1}),
        .abort     (abort_s),
        .m_tready  (m_tready),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tlast   (m_tlast),
        .slot_free (slot_free_s)
    );

endmodule

// File: tb/tb_zynq_fifo_drain.sv
// Directed bench for zynq_fifo_drain with a FWFT FIFO model and a beat recorder.
module tb_zynq_fifo_drain;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [11:0] fifo_count;
    logic        fifo_empty;
    logic [15:0] fifo_dout;
    logic        fifo_rd;
    logic        fifo_rd_en;
    logic        zynq_rd_rq;
    logic [11:0] howmany_left;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic        busy;
    logic        err;
    logic [15:0] frame_cnt;

    int total;
    int bad;

    // FIFO model
    logic [15:0] mem [0:8191];
    logic [12:0] rd_ptr;
    logic [12:0] wr_ptr;
    logic        cnt_force;
    logic [11:0] cnt_force_val;

    // Recorder
    logic [32:0] beat_mem [0:4095];
    int          beat_cnt;
    int          pop_cnt;
    int          stall_viol;
    logic        hold_r;
    logic [31:0] hold_data;
    logic        hold_last;
    logic [3:0]  pat;

    assign fifo_count = cnt_force ? cnt_force_val : 12'(wr_ptr - rd_ptr);
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_dout  = mem[rd_ptr];

    zynq_fifo_drain dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .fifo_count   (fifo_count),
        .fifo_empty   (fifo_empty),
        .fifo_dout    (fifo_dout),
        .fifo_rd      (fifo_rd),
        .fifo_rd_en   (fifo_rd_en),
        .zynq_rd_rq   (zynq_rd_rq),
        .howmany_left (howmany_left),
        .m_tdata      (m_tdata),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .m_tlast      (m_tlast),
        .busy         (busy),
        .err          (err),
        .frame_cnt    (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO read pointer, beat capture, pop count and hold-stability monitor.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr     <= 13'd0;
            beat_cnt   <= 0;
            pop_cnt    <= 0;
            stall_viol <= 0;
            hold_r     <= 1'b0;
            hold_data  <= 32'h0;
            hold_last  <= 1'b0;
        end else begin
            if (fifo_rd) begin
                rd_ptr  <= rd_ptr + 13'd1;
                pop_cnt <= pop_cnt + 1;
            end
            if (m_tvalid && m_tready && beat_cnt < 4096) begin
                beat_mem[beat_cnt] <= {m_tlast, m_tdata};
                beat_cnt           <= beat_cnt + 1;
            end
            if (hold_r && (!m_tvalid || m_tdata !== hold_data || m_tlast !== hold_last))
                stall_viol <= stall_viol + 1;
            hold_r    <= m_tvalid & ~m_tready;
            hold_data <= m_tdata;
            hold_last <= m_tlast;
        end
    end

    task automatic push_sample(input logic [15:0] v);
        mem[wr_ptr] = v;
        wr_ptr      = wr_ptr + 13'd1;
    endtask

    // Start pulse, grant three cycles into the request, then wait for IDLE.
    task automatic kick(input int budget, input bit toggle,
                        output logic [11:0] left0, output logic rq0, output logic err0);
        bit done;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; cnt_force = 1'b0;
        left0 = howmany_left; rq0 = zynq_rd_rq; err0 = err;
        repeat (3) @(negedge clk);
        fifo_rd_en = 1'b1;
        @(negedge clk); fifo_rd_en = 1'b0;
        total++;
        if (zynq_rd_rq !== 1'b0) begin
            bad++; $display("FAIL rq_release got=%b want=0", zynq_rd_rq);
        end
        done = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (toggle) m_tready = pat[c % 4];
            @(negedge clk);
            if (!busy) begin done = 1'b1; break; end
        end
        m_tready = 1'b1;
        total++;
        if (!done) begin
            bad++; $display("FAIL frame_timeout got=busy want=idle within %0d cycles", budget);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        total++;
        if ({m_tvalid, m_tlast, busy, zynq_rd_rq, err, fifo_rd} !== 6'b0 || m_tdata !== 32'h0) begin
            bad++; $display("FAIL reset_in got=%b/%h want=0", {m_tvalid, m_tlast, busy, zynq_rd_rq, err, fifo_rd}, m_tdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (howmany_left !== 12'd0 || frame_cnt !== 16'd0 || busy !== 1'b0 || m_tvalid !== 1'b0) begin
            bad++; $display("FAIL reset_out got=%h/%h/%b/%b want=0", howmany_left, frame_cnt, busy, m_tvalid);
        end
    endtask

    task automatic test_even4;
        logic [32:0] exp_b [0:2];
        logic [11:0] left0; logic rq0; logic err0;
        int bb, bp;
        bb = beat_cnt; bp = pop_cnt;
        push_sample(16'h1111); push_sample(16'h2222); push_sample(16'h3333); push_sample(16'h4444);
        exp_b[0] = {1'b0, 32'hA5C3_0004};
        exp_b[1] = {1'b0, 32'h2222_1111};
        exp_b[2] = {1'b1, 32'h4444_3333};
        kick(200, 1'b0, left0, rq0, err0);
        total++; if (left0 !== 12'd4) begin bad++; $display("FAIL even4_left0 got=%0d want=4", left0); end
        total++; if (rq0 !== 1'b1) begin bad++; $display("FAIL even4_rq got=%b want=1", rq0); end
        total++; if (beat_cnt - bb !== 3) begin bad++; $display("FAIL even4_nbeats got=%0d want=3", beat_cnt - bb); end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (beat_mem[bb + i] !== exp_b[i]) begin
                bad++; $display("FAIL even4_beat%0d got=%h want=%h", i, beat_mem[bb + i], exp_b[i]);
            end
        end
        total++; if (howmany_left !== 12'd0) begin bad++; $display("FAIL even4_left got=%0d want=0", howmany_left); end
        total++; if (frame_cnt !== 16'd1) begin bad++; $display("FAIL even4_frames got=%0d want=1", frame_cnt); end
        total++; if (pop_cnt - bp !== 4) begin bad++; $display("FAIL even4_pops got=%0d want=4", pop_cnt - bp); end
    endtask

    task automatic test_odd3;
        logic [32:0] exp_b [0:2];
        logic [11:0] left0; logic rq0; logic err0;
        int bb, bp;
        bb = beat_cnt; bp = pop_cnt;
        push_sample(16'hA001); push_sample(16'hA002); push_sample(16'hA003);
        exp_b[0] = {1'b0, 32'hA5C3_0003};
        exp_b[1] = {1'b0, 32'hA002_A001};
        exp_b[2] = {1'b1, 32'h0000_A003};
        kick(200, 1'b0, left0, rq0, err0);
        total++; if (beat_cnt - bb !== 3) begin bad++; $display("FAIL odd3_nbeats got=%0d want=3", beat_cnt - bb); end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (beat_mem[bb + i] !== exp_b[i]) begin
                bad++; $display("FAIL odd3_beat%0d got=%h want=%h", i, beat_mem[bb + i], exp_b[i]);
            end
        end
        total++; if (pop_cnt - bp !== 3) begin bad++; $display("FAIL odd3_pops got=%0d want=3", pop_cnt - bp); end
        total++; if (frame_cnt !== 16'd2) begin bad++; $display("FAIL odd3_frames got=%0d want=2", frame_cnt); end
    endtask

    task automatic test_clamp;
        logic [11:0] left0; logic rq0; logic err0;
        logic [15:0] lo, hi;
        logic [32:0] want;
        int bb, bp, nerr;
        bb = beat_cnt; bp = pop_cnt;
        for (int i = 0; i < 3000; i++) push_sample(16'(i) ^ 16'h3C00);
        kick(6000, 1'b0, left0, rq0, err0);
        total++; if (left0 !== 12'd2048) begin bad++; $display("FAIL clamp_n got=%0d want=2048", left0); end
        total++; if (beat_cnt - bb !== 1025) begin bad++; $display("FAIL clamp_nbeats got=%0d want=1025", beat_cnt - bb); end
        total++; if (beat_mem[bb] !== {1'b0, 32'hA5C3_0800}) begin bad++; $display("FAIL clamp_hdr got=%h want=0a5c30800", beat_mem[bb]); end
        nerr = 0;
        for (int k = 0; k < 1024; k++) begin
            lo   = 16'(2 * k) ^ 16'h3C00;
            hi   = 16'(2 * k + 1) ^ 16'h3C00;
            want = {(k == 1023) ? 1'b1 : 1'b0, hi, lo};
            if (beat_mem[bb + 1 + k] !== want) nerr++;
        end
        total++; if (nerr !== 0) begin bad++; $display("FAIL clamp_data got=%0d bad beats want=0", nerr); end
        total++; if (fifo_count !== 12'd952) begin bad++; $display("FAIL clamp_remain got=%0d want=952", fifo_count); end
        total++; if (pop_cnt - bp !== 2048) begin bad++; $display("FAIL clamp_pops got=%0d want=2048", pop_cnt - bp); end
        total++; if (frame_cnt !== 16'd3) begin bad++; $display("FAIL clamp_frames got=%0d want=3", frame_cnt); end
        wr_ptr = rd_ptr;
    endtask

    task automatic test_backpressure;
        logic [11:0] left0; logic rq0; logic err0;
        logic [32:0] want;
        int bb, bp, sv, nerr;
        bb = beat_cnt; bp = pop_cnt; sv = stall_viol;
        for (int i = 0; i < 8; i++) push_sample(16'hB000 + 16'(i));
        kick(400, 1'b1, left0, rq0, err0);
        total++; if (beat_cnt - bb !== 5) begin bad++; $display("FAIL bp_nbeats got=%0d want=5", beat_cnt - bb); end
        total++; if (beat_mem[bb] !== {1'b0, 32'hA5C3_0008}) begin bad++; $display("FAIL bp_hdr got=%h want=0a5c30008", beat_mem[bb]); end
        nerr = 0;
        for (int k = 0; k < 4; k++) begin
            want = {(k == 3) ? 1'b1 : 1'b0, 16'hB000 + 16'(2 * k + 1), 16'hB000 + 16'(2 * k)};
            if (beat_mem[bb + 1 + k] !== want) nerr++;
        end
        total++; if (nerr !== 0) begin bad++; $display("FAIL bp_data got=%0d bad beats want=0", nerr); end
        total++; if (stall_viol - sv !== 0) begin bad++; $display("FAIL bp_hold got=%0d changes want=0", stall_viol - sv); end
        total++; if (pop_cnt - bp !== 8) begin bad++; $display("FAIL bp_pops got=%0d want=8", pop_cnt - bp); end
        total++; if (frame_cnt !== 16'd4) begin bad++; $display("FAIL bp_frames got=%0d want=4", frame_cnt); end
    endtask

    task automatic test_timeout_partial;
        logic [32:0] exp_b [0:2];
        logic [11:0] left0; logic rq0; logic err0;
        int bb, bp;
        bb = beat_cnt; bp = pop_cnt;
        push_sample(16'hC001); push_sample(16'hC002); push_sample(16'hC003);
        cnt_force_val = 12'd5; cnt_force = 1'b1;
        exp_b[0] = {1'b0, 32'hA5C3_0005};
        exp_b[1] = {1'b0, 32'hC002_C001};
        exp_b[2] = {1'b1, 32'h0000_C003};
        kick(1000, 1'b0, left0, rq0, err0);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL to_err got=%b want=1", err); end
        total++; if (howmany_left !== 12'd0) begin bad++; $display("FAIL to_left got=%0d want=0", howmany_left); end
        total++; if (beat_cnt - bb !== 3) begin bad++; $display("FAIL to_nbeats got=%0d want=3", beat_cnt - bb); end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (beat_mem[bb + i] !== exp_b[i]) begin
                bad++; $display("FAIL to_beat%0d got=%h want=%h", i, beat_mem[bb + i], exp_b[i]);
            end
        end
        total++; if (pop_cnt - bp !== 3) begin bad++; $display("FAIL to_pops got=%0d want=3", pop_cnt - bp); end
        total++; if (frame_cnt !== 16'd5) begin bad++; $display("FAIL to_frames got=%0d want=5", frame_cnt); end
    endtask

    task automatic test_timeout_empty;
        logic [11:0] left0; logic rq0; logic err0;
        int bb;
        bb = beat_cnt;
        wr_ptr = rd_ptr;
        cnt_force_val = 12'd2; cnt_force = 1'b1;
        kick(1000, 1'b0, left0, rq0, err0);
        total++; if (err0 !== 1'b0) begin bad++; $display("FAIL toe_errclr got=%b want=0", err0); end
        total++; if (beat_mem[bb] !== {1'b0, 32'hA5C3_0002}) begin bad++; $display("FAIL toe_hdr got=%h want=0a5c30002", beat_mem[bb]); end
        total++; if (beat_mem[bb + 1] !== {1'b1, 32'hDEAD_0000}) begin bad++; $display("FAIL toe_abort got=%h want=1dead0000", beat_mem[bb + 1]); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL toe_err got=%b want=1", err); end
        total++; if (frame_cnt !== 16'd6) begin bad++; $display("FAIL toe_frames got=%0d want=6", frame_cnt); end
    endtask

    task automatic test_reset_mid;
        logic [11:0] left0; logic rq0; logic err0;
        int bb, bp, c;
        bp = pop_cnt;
        for (int i = 0; i < 8; i++) push_sample(16'hE000 + 16'(i));
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        fifo_rd_en = 1'b1;
        @(negedge clk); fifo_rd_en = 1'b0;
        c = 0;
        while (pop_cnt - bp < 2 && c < 100) begin @(negedge clk); c++; end
        total++; if (pop_cnt - bp < 2) begin bad++; $display("FAIL rm_reach_data got=%0d pops want>=2", pop_cnt - bp); end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({m_tvalid, m_tlast, busy, zynq_rd_rq, err, fifo_rd} !== 6'b0 || m_tdata !== 32'h0 ||
            howmany_left !== 12'd0 || frame_cnt !== 16'd0) begin
            bad++; $display("FAIL rm_async got=%b/%h/%h/%h want=0", {m_tvalid, m_tlast, busy, zynq_rd_rq, err, fifo_rd},
                            m_tdata, howmany_left, frame_cnt);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        wr_ptr = rd_ptr;
        bb = beat_cnt; bp = pop_cnt;
        push_sample(16'hD001); push_sample(16'hD002);
        kick(200, 1'b0, left0, rq0, err0);
        total++; if (beat_mem[bb] !== {1'b0, 32'hA5C3_0002}) begin bad++; $display("FAIL rm_hdr got=%h want=0a5c30002", beat_mem[bb]); end
        total++; if (beat_mem[bb + 1] !== {1'b1, 32'hD002_D001}) begin bad++; $display("FAIL rm_beat got=%h want=1d002d001", beat_mem[bb + 1]); end
        total++; if (pop_cnt - bp !== 2) begin bad++; $display("FAIL rm_pops got=%0d want=2", pop_cnt - bp); end
        total++; if (frame_cnt !== 16'd1) begin bad++; $display("FAIL rm_frames got=%0d want=1", frame_cnt); end
    endtask

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0; start = 1'b0; fifo_rd_en = 1'b0; m_tready = 1'b1;
        wr_ptr = 13'd0; cnt_force = 1'b0; cnt_force_val = 12'd0;
        pat = 4'b1001;
        test_reset();
        test_even4();
        test_odd3();
        test_clamp();
        test_backpressure();
        test_timeout_partial();
        test_timeout_empty();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
